// File: rtl/sap1_prog_port.sv
`default_nettype none
// ============================================================================
// Module   : sap1_prog_port
// Purpose  : SAP-1 front-panel programming port: debounced one-shot RAM writes
//            in PROG mode, MAR-addressed bus reads in RUN mode.
// Revision : 1.0 - initial release
// ============================================================================
module sap1_prog_port #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ch_s2,
  input  logic             ch_s4,
  input  logic [3:0]       a,
  input  logic [7:0]       d,
  input  logic [3:0]       mar_addr,
  input  logic             n_ce,
  output logic [7:0]       ram_out,
  output logic             wr_ack,
  output logic [3:0]       last_addr,
  output logic [7:0]       last_data,
  output logic [CNT_W-1:0] wr_count,
  output logic [2:0]       temp_state
);

  localparam int            CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic [2:0] {
    S_RUN   = 3'd0,
    S_IDLE  = 3'd1,
    S_PRESS = 3'd2,
    S_WRITE = 3'd3,
    S_HOLD  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s2_meta_q, s2_s_q;
  logic             s4_meta_q, s4_s_q;
  logic [3:0]       a_r_q;
  logic [7:0]       d_r_q;
  logic [3:0]       wa_q;
  logic [7:0]       wd_q;
  logic             latch_w;
  logic [3:0]       last_addr_q;
  logic [7:0]       last_data_q;
  logic [CNT_W-1:0] wr_count_q;
  logic [7:0]       mem_q [16];

  // Input conditioning: 2-flop sync for the switches, single stage for buses
  always_ff @(posedge clk) begin
    if (clr) begin
      s2_meta_q <= 1'b0;
      s2_s_q    <= 1'b0;
      s4_meta_q <= 1'b0;
      s4_s_q    <= 1'b0;
      a_r_q     <= 4'h0;
      d_r_q     <= 8'h00;
    end else begin
      s2_meta_q <= ch_s2;
      s2_s_q    <= s2_meta_q;
      s4_meta_q <= ch_s4;
      s4_s_q    <= s4_meta_q;
      a_r_q     <= a;
      d_r_q     <= d;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      wa_q    <= 4'h0;
      wd_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_w) begin
        wa_q <= a_r_q;
        wd_q <= d_r_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch_w = 1'b0;
    case (state_q)
      S_RUN: begin
        // Entering PROG goes through HOLD so a held button cannot write
        if (s2_s_q) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      end
      S_IDLE: begin
        if (!s2_s_q) begin
          state_d = S_RUN;
        end else if (s4_s_q) begin
          state_d = S_PRESS;
          cnt_d   = '0;
        end
      end
      S_PRESS: begin
        if (!s2_s_q) begin
          state_d = S_RUN;
        end else if (!s4_s_q) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_WRITE;
          latch_w = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WRITE: begin
        state_d = S_HOLD;
        cnt_d   = '0;
      end
      S_HOLD: begin
        if (!s2_s_q) begin
          state_d = S_RUN;
        end else if (s4_s_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      last_addr_q <= 4'h0;
      last_data_q <= 8'h00;
      wr_count_q  <= '0;
    end else if (state_q == S_WRITE) begin
      last_addr_q <= wa_q;
      last_data_q <= wd_q;
      if (wr_count_q != {CNT_W{1'b1}}) begin
        wr_count_q <= wr_count_q + 1'b1;
      end
    end
  end

  // RAM contents survive clr; a write coinciding with clr is dropped
  always_ff @(posedge clk) begin
    if (!clr && state_q == S_WRITE) begin
      mem_q[wa_q] <= wd_q;
    end
  end

  assign ram_out    = (!s2_s_q && !n_ce) ? mem_q[mar_addr] : 8'h00;
  assign wr_ack     = (state_q == S_WRITE);
  assign last_addr  = last_addr_q;
  assign last_data  = last_data_q;
  assign wr_count   = wr_count_q;
  assign temp_state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_sap1_prog_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_sap1_prog_port
// Purpose  : Directed self-checking bench for sap1_prog_port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sap1_prog_port;

  localparam int DEB_CYCLES = 4;
  localparam int CNT_W      = 5;

  logic             clk = 1'b0;
  logic             clr = 1'b0;
  logic             ch_s2 = 1'b1;
  logic             ch_s4 = 1'b0;
  logic [3:0]       a = 4'h0;
  logic [7:0]       d = 8'h00;
  logic [3:0]       mar_addr = 4'h0;
  logic             n_ce = 1'b1;
  logic [7:0]       ram_out;
  logic             wr_ack;
  logic [3:0]       last_addr;
  logic [7:0]       last_data;
  logic [CNT_W-1:0] wr_count;
  logic [2:0]       temp_state;

  int checks   = 0;
  int failures = 0;

  sap1_prog_port #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .clr        (clr),
    .ch_s2      (ch_s2),
    .ch_s4      (ch_s4),
    .a          (a),
    .d          (d),
    .mar_addr   (mar_addr),
    .n_ce       (n_ce),
    .ram_out    (ram_out),
    .wr_ack     (wr_ack),
    .last_addr  (last_addr),
    .last_data  (last_data),
    .wr_count   (wr_count),
    .temp_state (temp_state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Settle, hold button for hi cycles, release; counts wr_ack pulses and
  // records the cycle index (1 = first edge sampling the press) of the first one.
  task automatic press(input int hi, input int chg, output int pulses, output int lat);
    pulses = 0;
    lat    = 0;
    idle(10);
    ch_s4 = 1'b1;
    for (int k = 1; k <= hi; k++) begin
      @(negedge clk);
      if (wr_ack) begin
        pulses++;
        if (lat == 0) lat = k;
      end
      if (k == chg) begin
        a = 4'hF;
        d = 8'hFF;
      end
    end
    ch_s4 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (wr_ack) pulses++;
    end
  endtask

  initial begin
    int p, l;
    bit seen;

    // Reset state
    @(negedge clk);
    a = 4'h3; d = 8'hA5; clr = 1'b1;
    idle(2);
    clr = 1'b0;
    check_val("rst_state", temp_state, 3'd4);
    check_val("rst_ack", wr_ack, 0);
    check_val("rst_count", wr_count, 0);
    check_val("rst_laddr", last_addr, 0);
    check_val("rst_ldata", last_data, 0);

    // One write, latency DEB_CYCLES+2 edges after the sampling edge
    press(10, 0, p, l);
    check_val("t1_pulses", p, 1);
    check_val("t1_latency", l, DEB_CYCLES + 3);
    check_val("t1_laddr", last_addr, 4'h3);
    check_val("t1_ldata", last_data, 8'hA5);
    check_val("t1_count", wr_count, 1);

    // Glitch shorter than debounce window
    a = 4'h4; d = 8'h44;
    press(2, 0, p, l);
    check_val("t2_pulses", p, 0);
    check_val("t2_count", wr_count, 1);

    // Long hold with data change after latch
    a = 4'h5; d = 8'h5A;
    press(100, 20, p, l);
    check_val("t3_pulses", p, 1);
    check_val("t3_laddr", last_addr, 4'h5);
    check_val("t3_ldata", last_data, 8'h5A);
    check_val("t3_count", wr_count, 2);

    // Fill RAM then read back through the bus
    for (int i = 0; i < 16; i++) begin
      a = 4'(i); d = 8'(8'h10 + i);
      press(10, 0, p, l);
      check_val("t4_pulse", p, 1);
    end
    check_val("t4_count", wr_count, 18);
    n_ce = 1'b0; mar_addr = 4'h7;
    @(negedge clk);
    check_val("t4_prog_noread", ram_out, 8'h00);
    ch_s2 = 1'b0;
    idle(4);
    check_val("t4_run_state", temp_state, 3'd0);
    for (int i = 0; i < 16; i++) begin
      mar_addr = 4'(i);
      #1;
      check_val("t4_read", ram_out, 8'(8'h10 + i));
    end
    n_ce = 1'b1;
    #1;
    check_val("t4_nce_off", ram_out, 8'h00);

    // Mode toggling with button held never writes until release and re-press
    p = 0;
    ch_s4 = 1'b1; ch_s2 = 1'b1;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (wr_ack) p++; end
    check_val("t5_state_a", temp_state, 3'd4);
    ch_s2 = 1'b0;
    for (int k = 0; k < 5; k++) begin @(negedge clk); if (wr_ack) p++; end
    ch_s2 = 1'b1;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (wr_ack) p++; end
    check_val("t5_nowrite", p, 0);
    check_val("t5_state_b", temp_state, 3'd4);
    ch_s4 = 1'b0;
    a = 4'h9; d = 8'h99;
    press(10, 0, p, l);
    check_val("t5_repress", p, 1);
    check_val("t5_count", wr_count, 19);

    // Reset landing on the write cycle drops the write
    idle(10);
    a = 4'h2; d = 8'hEE; ch_s4 = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (wr_ack) seen = 1'b1;
    end
    check_val("t6_ack_seen", seen, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_val("t6_state", temp_state, 3'd4);
    check_val("t6_count", wr_count, 0);
    check_val("t6_laddr", last_addr, 0);
    ch_s4 = 1'b0; ch_s2 = 1'b0;
    idle(4);
    n_ce = 1'b0; mar_addr = 4'h2;
    #1;
    check_val("t6_mem_kept", ram_out, 8'h12);
    n_ce = 1'b1; ch_s2 = 1'b1;

    // Saturation of the write counter
    for (int i = 0; i < 33; i++) begin
      a = 4'(i); d = 8'(i);
      press(8, 0, p, l);
    end
    check_val("t6_saturate", wr_count, 31);
    check_val("t6_sat_laddr", last_addr, 4'(32));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
